// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//   Instruction-memory responder for the fetch side of the RISC-V core.
//   Fetch requests (byte address) are accepted on a valid/ready channel, the
//   word array is read in the accept cycle, and {data, err} travel through a
//   LATENCY-stage valid pipeline into an output FIFO drained under
//   backpressure. A separate load port writes the word array at any time.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req_valid/req_ready   fetch request handshake
//   req_addr [WIDTH]      byte address (PC)
//   rsp_valid/rsp_ready   response handshake (FIFO head)
//   rsp_data [WIDTH]      instruction word (0 when no response)
//   rsp_err               misaligned / out-of-range fetch
//   ld_we, ld_addr, ld_data  load-port word write
// -----------------------------------------------------------------------------
module imem_responder #(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2,
   parameter int unsigned OUT_DEPTH   = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           req_valid,
   input  logic [WIDTH-1:0]               req_addr,
   output logic                           req_ready,
   output logic                           rsp_valid,
   output logic [WIDTH-1:0]               rsp_data,
   output logic                           rsp_err,
   input  logic                           rsp_ready,
   input  logic                           ld_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
   input  logic [WIDTH-1:0]               ld_data
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned PW = $clog2(OUT_DEPTH);
   localparam int unsigned CW = $clog2(OUT_DEPTH + 1);

   // Word array (not reset)
   logic [WIDTH-1:0] mem [DEPTH_WORDS];

   // Outstanding counter: in-flight pipeline entries plus FIFO entries
   logic [CW-1:0] out_cnt;

   logic             accept;
   logic             pop;
   logic             push;

   // Decode of the presented address
   logic             addr_err;
   logic [AW-1:0]    word_idx;
   logic [WIDTH-1:0] rd_data;

   // Response pipeline
   logic             pipe_v [LATENCY];
   logic [WIDTH-1:0] pipe_d [LATENCY];
   logic             pipe_e [LATENCY];

   // Output FIFO; pointers carry one extra wrap bit to tell full from empty
   logic [WIDTH-1:0] fifo_d [OUT_DEPTH];
   logic             fifo_e [OUT_DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             fifo_empty;
   logic             fifo_full;

   assign req_ready  = (out_cnt < CW'(OUT_DEPTH));
   assign accept     = req_valid & req_ready;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                       (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign rsp_valid  = ~fifo_empty;
   assign pop        = rsp_valid & rsp_ready;
   assign push       = pipe_v[LATENCY-1];

   assign rsp_data   = rsp_valid ? fifo_d[rd_ptr[PW-1:0]] : '0;
   assign rsp_err    = rsp_valid ? fifo_e[rd_ptr[PW-1:0]] : 1'b0;

   // Faulting fetches return a NOP so a speculative consumer stays harmless.
   always_comb begin
      addr_err = (req_addr[1:0] != 2'b00) ||
                 ((req_addr >> 2) >= WIDTH'(DEPTH_WORDS));
      word_idx = req_addr[AW+1:2];
      rd_data  = addr_err ? WIDTH'(32'h0000_0013) : mem[word_idx];
   end

   // Array read above happens before this write lands, so a same-cycle
   // fetch of the word being loaded sees the old contents.
   always_ff @(posedge clk) begin
      if (ld_we) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // Pipeline valid bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < LATENCY; i++) begin
            pipe_v[i] <= 1'b0;
         end
      end else begin
         pipe_v[0] <= accept;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
         end
      end
   end

   // Pipeline payload; qualified by pipe_v so needs no reset
   always_ff @(posedge clk) begin
      pipe_d[0] <= rd_data;
      pipe_e[0] <= addr_err;
      for (int unsigned i = 1; i < LATENCY; i++) begin
         pipe_d[i] <= pipe_d[i-1];
         pipe_e[i] <= pipe_e[i-1];
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_d[wr_ptr[PW-1:0]] <= pipe_d[LATENCY-1];
         fifo_e[wr_ptr[PW-1:0]] <= pipe_e[LATENCY-1];
      end
   end

   // FIFO pointers and outstanding counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         out_cnt <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({accept, pop})
            2'b10:   out_cnt <= out_cnt + 1'b1;
            2'b01:   out_cnt <= out_cnt - 1'b1;
            default: out_cnt <= out_cnt;
         endcase
      end
   end

   // req_ready bounds outstanding work to OUT_DEPTH, so a push never meets
   // a full FIFO.
   assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
//   Self-checking bench for imem_responder. A transaction-level reference
//   model (in-flight queue with due times, output queue, shadow word array)
//   predicts the DUT outputs; scenario tasks add fixed expectations.
// -----------------------------------------------------------------------------
module tb_imem_responder;

   localparam int WIDTH       = 32;
   localparam int DEPTH_WORDS = 256;
   localparam int LATENCY     = 2;
   localparam int OUT_DEPTH   = 4;
   localparam int AW          = 8;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic [WIDTH-1:0]  req_addr = '0;
   logic              req_ready;
   logic              rsp_valid;
   logic [WIDTH-1:0]  rsp_data;
   logic              rsp_err;
   logic              rsp_ready = 1'b0;
   logic              ld_we = 1'b0;
   logic [AW-1:0]     ld_addr = '0;
   logic [WIDTH-1:0]  ld_data = '0;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] prog [4];

   imem_responder #(
      .WIDTH       (WIDTH),
      .DEPTH_WORDS (DEPTH_WORDS),
      .LATENCY     (LATENCY),
      .OUT_DEPTH   (OUT_DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .rsp_ready (rsp_ready),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [31:0] d;
      logic        e;
      int          due;
   } ent_t;

   ent_t        inflight [$];
   ent_t        outq     [$];
   logic [31:0] mem_m    [DEPTH_WORDS];
   int          edge_cnt = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight.delete();
         outq.delete();
      end else begin
         bit   do_pop;
         bit   do_acc;
         ent_t t;
         do_pop = (outq.size() > 0) && rsp_ready;
         do_acc = req_valid && ((inflight.size() + outq.size()) < OUT_DEPTH);
         edge_cnt++;
         if (do_pop) void'(outq.pop_front());
         while (inflight.size() > 0 && inflight[0].due == edge_cnt)
            outq.push_back(inflight.pop_front());
         if (do_acc) begin
            t.e   = (req_addr % 4 != 0) || ((req_addr / 4) >= DEPTH_WORDS);
            t.d   = t.e ? 32'h0000_0013 : mem_m[req_addr / 4];
            t.due = edge_cnt + LATENCY;
            inflight.push_back(t);
         end
         if (ld_we) mem_m[ld_addr] = ld_data;
      end
   end

   function automatic void model_out(output logic v, output logic [31:0] d,
                                     output logic e, output logic r);
      v = outq.size() > 0;
      d = v ? outq[0].d : 32'h0;
      e = v ? outq[0].e : 1'b0;
      r = (inflight.size() + outq.size()) < OUT_DEPTH;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 9))
         0:       a = {22'h0, $urandom_range(0, 1023)} | 32'h1 << $urandom_range(0, 1);
         1:       a = {$urandom_range(256, 32'h3FFF_FFFF), 2'b00};
         default: a = {22'h0, $urandom_range(0, 255), 2'b00};
      endcase
      return a;
   endfunction

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load_word(input int idx, input logic [31:0] val);
      ld_we   = 1'b1;
      ld_addr = AW'(idx);
      ld_data = val;
      cycle();
      ld_we   = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_hold: got ready=%b valid=%b data=%h err=%b, expected 1 0 00000000 0",
                  req_ready, rsp_valid, rsp_data, rsp_err);
      end
      cycle();
      reset = 1'b0;
      cycle();
      n_checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release: got ready=%b valid=%b data=%h err=%b, expected 1 0 00000000 0",
                  req_ready, rsp_valid, rsp_data, rsp_err);
      end
      for (int i = 0; i < DEPTH_WORDS; i++)
         load_word(i, (i < 4) ? prog[i] : (i == 5) ? 32'hAAAA_0000 : $urandom);
   endtask

   task automatic test_basic_stream();
      logic ev, ee, er;
      logic [31:0] ed;
      rsp_ready = 1'b1;
      for (int k = 0; k < LATENCY + 6; k++) begin
         if (k < 4) begin
            req_valid = 1'b1;
            req_addr  = 32'(4 * k);
            n_checks++;
            if (req_ready !== 1'b1) begin
               n_errors++;
               $display("FAIL basic_ready k=%0d: got %b, expected 1", k, req_ready);
            end
         end else begin
            req_valid = 1'b0;
         end
         cycle();
         ev = (k >= LATENCY) && (k < LATENCY + 4);
         ed = ev ? prog[k - LATENCY] : 32'h0;
         n_checks++;
         if (rsp_valid !== ev || rsp_data !== ed || rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_rsp k=%0d: got valid=%b data=%h err=%b, expected valid=%b data=%h err=0",
                     k, rsp_valid, rsp_data, rsp_err, ev, ed);
         end
         model_out(ev, ed, ee, er);
         n_checks++;
         if (rsp_valid !== ev || rsp_data !== ed || rsp_err !== ee || req_ready !== er) begin
            n_errors++;
            $display("FAIL basic_model: got v=%b d=%h e=%b r=%b, expected v=%b d=%h e=%b r=%b",
                     rsp_valid, rsp_data, rsp_err, req_ready, ev, ed, ee, er);
         end
      end
   endtask

   task automatic test_faults();
      logic [31:0] bad [3];
      int got = 0;
      bad[0] = 32'h0000_0002;
      bad[1] = 32'h0000_0400;
      bad[2] = 32'hFFFF_FFFC;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1;
         req_addr  = bad[i];
         cycle();
      end
      req_valid = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (rsp_valid === 1'b1) begin
            got++;
            n_checks++;
            if (rsp_err !== 1'b1 || rsp_data !== 32'h0000_0013) begin
               n_errors++;
               $display("FAIL fault_rsp #%0d: got err=%b data=%h, expected err=1 data=00000013",
                        got, rsp_err, rsp_data);
            end
         end
         cycle();
      end
      n_checks++;
      if (got != 3) begin
         n_errors++;
         $display("FAIL fault_count: got %0d responses, expected 3", got);
      end
   endtask

   task automatic test_backpressure();
      logic ev, ee, er;
      logic [31:0] ed;
      int acc = 0;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         req_addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         if (req_ready === 1'b1) acc++;
         cycle();
         model_out(ev, ed, ee, er);
         n_checks++;
         if (rsp_valid !== ev || rsp_data !== ed || rsp_err !== ee || req_ready !== er) begin
            n_errors++;
            $display("FAIL bp_model: got v=%b d=%h e=%b r=%b, expected v=%b d=%h e=%b r=%b",
                     rsp_valid, rsp_data, rsp_err, req_ready, ev, ed, ee, er);
         end
      end
      n_checks++;
      if (acc != OUT_DEPTH || req_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_accepts: got accepts=%0d ready=%b, expected accepts=%0d ready=0",
                  acc, req_ready, OUT_DEPTH);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      cycle();
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL bp_ready_return: got %b, expected 1", req_ready);
      end
      for (int i = 0; i < 8; i++) begin
         model_out(ev, ed, ee, er);
         n_checks++;
         if (rsp_valid !== ev || rsp_data !== ed || rsp_err !== ee || req_ready !== er) begin
            n_errors++;
            $display("FAIL bp_drain: got v=%b d=%h e=%b r=%b, expected v=%b d=%h e=%b r=%b",
                     rsp_valid, rsp_data, rsp_err, req_ready, ev, ed, ee, er);
         end
         cycle();
      end
      n_checks++;
      if (rsp_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL bp_empty: got valid=%b, expected 0", rsp_valid);
      end
   endtask

   task automatic test_full_stream();
      logic ev, ee, er;
      logic [31:0] ed;
      int pops = 0;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_addr = rand_addr();
         cycle();
      end
      rsp_ready = 1'b1;
      for (int c = 0; c < 200 && pops < 20; c++) begin
         req_addr = rand_addr();
         if (rsp_valid === 1'b1) pops++;
         cycle();
         model_out(ev, ed, ee, er);
         n_checks++;
         if (rsp_valid !== ev || rsp_data !== ed || rsp_err !== ee || req_ready !== er) begin
            n_errors++;
            $display("FAIL full_model: got v=%b d=%h e=%b r=%b, expected v=%b d=%h e=%b r=%b",
                     rsp_valid, rsp_data, rsp_err, req_ready, ev, ed, ee, er);
         end
      end
      n_checks++;
      if (pops != 20) begin
         n_errors++;
         $display("FAIL full_pops: got %0d pops within budget, expected 20", pops);
      end
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
   endtask

   task automatic test_collision();
      logic [31:0] exp_d [2];
      int got = 0;
      exp_d[0] = 32'hAAAA_0000;
      exp_d[1] = 32'h1234_5678;
      rsp_ready = 1'b1;
      load_word(5, 32'hAAAA_0000);
      ld_we     = 1'b1;
      ld_addr   = AW'(5);
      ld_data   = 32'h1234_5678;
      req_valid = 1'b1;
      req_addr  = 32'h14;
      cycle();
      ld_we = 1'b0;
      cycle();
      req_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid === 1'b1) begin
            n_checks++;
            if (got > 1 || rsp_data !== exp_d[got] || rsp_err !== 1'b0) begin
               n_errors++;
               $display("FAIL collision_rsp #%0d: got data=%h err=%b, expected data=%h err=0",
                        got, rsp_data, rsp_err, exp_d[got & 1]);
            end
            got++;
         end
         cycle();
      end
      n_checks++;
      if (got != 2) begin
         n_errors++;
         $display("FAIL collision_count: got %0d responses, expected 2", got);
      end
   endtask

   task automatic test_reset_midstream();
      int got = 0;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req_addr = 32'(4 * (i + 1));
         cycle();
      end
      req_valid = 1'b0;
      reset = 1'b1;
      #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_data !== 32'h0) begin
         n_errors++;
         $display("FAIL midreset_now: got valid=%b ready=%b data=%h, expected 0 1 00000000",
                  rsp_valid, req_ready, rsp_data);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cycle();
         n_checks++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_stale c=%0d: got valid=%b ready=%b, expected 0 1",
                     i, rsp_valid, req_ready);
         end
      end
      req_valid = 1'b1;
      req_addr  = 32'h0;
      cycle();
      req_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (rsp_valid === 1'b1) begin
            got++;
            n_checks++;
            if (rsp_data !== prog[0] || rsp_err !== 1'b0) begin
               n_errors++;
               $display("FAIL midreset_array: got data=%h err=%b, expected data=%h err=0",
                        rsp_data, rsp_err, prog[0]);
            end
         end
         cycle();
      end
      n_checks++;
      if (got != 1) begin
         n_errors++;
         $display("FAIL midreset_count: got %0d responses, expected 1", got);
      end
   endtask

   task automatic test_random();
      logic ev, ee, er;
      logic [31:0] ed;
      for (int c = 0; c < 2000; c++) begin
         req_valid = ($urandom_range(0, 2) != 0);
         req_addr  = rand_addr();
         rsp_ready = ($urandom_range(0, 3) != 0);
         ld_we     = ($urandom_range(0, 9) == 0);
         ld_addr   = AW'($urandom_range(0, 255));
         ld_data   = $urandom;
         cycle();
         model_out(ev, ed, ee, er);
         n_checks++;
         if (rsp_valid !== ev || rsp_data !== ed || rsp_err !== ee || req_ready !== er) begin
            n_errors++;
            $display("FAIL random_model c=%0d: got v=%b d=%h e=%b r=%b, expected v=%b d=%h e=%b r=%b",
                     c, rsp_valid, rsp_data, rsp_err, req_ready, ev, ed, ee, er);
         end
      end
      ld_we     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
   endtask

   initial begin
      prog[0] = 32'h0050_0093;
      prog[1] = 32'h0010_0113;
      prog[2] = 32'h0020_81B3;
      prog[3] = 32'h0000_0013;
      test_reset();
      test_basic_stream();
      test_faults();
      test_backpressure();
      test_full_stream();
      test_collision();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
